// File: rtl/scan_mux_n.sv
// scan_mux_n -- registered, parametrised N:1 channel selector.
//
// Two ways of picking the channel:
//   mode=0 : manual, the channel comes straight from sel_in.
//   mode=1 : round-robin scan over the enabled channels, holding each one
//            for DWELL cycles. A channel that becomes disabled is left on the
//            next edge without waiting for its dwell to finish.
// freeze holds the selection and the dwell counter in both modes. While
// frozen, dout keeps sampling din of the held channel.
// All outputs are registered, so there is no combinational path from any
// input to any output.
//
// Ports
//   clk      system clock, all state on the rising edge
//   rst_n    asynchronous active-low reset
//   din      packed channel data, channel i = din[i*WIDTH +: WIDTH]
//   en       channel enable mask, 1 = channel eligible
//   mode     0 = manual (sel_in), 1 = round-robin scan
//   sel_in   manual channel select
//   freeze   1 = hold selection and dwell counter
//   dout     selected channel data; 0 when the selection is invalid
//   sel_out  channel currently on dout
//   valid    dout carries an enabled, in-range channel
//   strobe   1-cycle pulse when sel_out changes or valid rises
module scan_mux_n #(
  parameter int WIDTH = 10,
  parameter int N     = 4,
  parameter int SEL_W = 2,
  parameter int DWELL = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] din,
  input  logic [N-1:0]       en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               freeze,
  output logic [WIDTH-1:0]   dout,
  output logic [SEL_W-1:0]   sel_out,
  output logic               valid,
  output logic               strobe
);

  localparam int             CW   = $clog2(DWELL + 1);
  localparam logic [SEL_W:0] N_L  = (SEL_W + 1)'(N);
  localparam logic [CW-1:0]  LAST = CW'(DWELL - 1);

  // Unpacked view of the packed input bus.
  logic [WIDTH-1:0] ch [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign ch[gi] = din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_next;
  logic [SEL_W-1:0] nxt_ch;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_next;
  logic             valid_next;
  logic [WIDTH-1:0] dout_next;

  // A select value names a usable channel only if it is in range and enabled.
  function automatic logic chan_ok(input logic [SEL_W-1:0] s, input logic [N-1:0] m);
    chan_ok = 1'b0;
    if ({1'b0, s} < N_L) chan_ok = m[s];
  endfunction

  // First enabled channel searching upward from sel_q+1, wrapping N-1 -> 0.
  // An out-of-range sel_q (possible when N is not a power of two) restarts
  // the search at channel 0. The loop runs downward so the nearest hit wins.
  // With a single enabled channel the search lands back on sel_q itself.
  always_comb begin
    int base;
    int c;
    nxt_ch = sel_q;
    base   = ({1'b0, sel_q} < N_L) ? int'(sel_q) + 1 : 0;
    c      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = base + k;
      if (c >= N) c = c - N;
      if (en[SEL_W'(c)]) nxt_ch = SEL_W'(c);
    end
  end

  always_comb begin
    sel_next = sel_q;
    cnt_next = cnt_q;
    if (!freeze) begin
      if (!mode) begin
        sel_next = sel_in;
        cnt_next = '0;
      end else if (en == '0) begin
        // Nothing to scan: park on the current channel with the count cleared.
        cnt_next = '0;
      end else if (!chan_ok(sel_q, en) || cnt_q == LAST) begin
        sel_next = nxt_ch;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_q + CW'(1);
      end
    end

    valid_next = chan_ok(sel_next, en);
    dout_next  = '0;
    for (int i = 0; i < N; i++) begin
      if (valid_next && sel_next == SEL_W'(i)) dout_next = ch[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
      strobe <= 1'b0;
    end else begin
      sel_q  <= sel_next;
      cnt_q  <= cnt_next;
      dout   <= dout_next;
      valid  <= valid_next;
      strobe <= (sel_next != sel_q) || (valid_next && !valid);
    end
  end

  assign sel_out = sel_q;

endmodule

// File: tb/tb_scan_mux_n.sv
// tb_scan_mux_n -- self-checking bench for scan_mux_n (N=4, WIDTH=10, DWELL=4).
// A behavioural model tracks which channel should be shown and how long it
// has been shown; a compare process checks every cycle on the falling edge.
// Directed sequences with literal expectations pin the model, then a
// randomized phase exercises mode/en/freeze/reset combinations.
module tb_scan_mux_n;

  localparam int W  = 10;
  localparam int NC = 4;
  localparam int SW = 2;
  localparam int DW = 4;

  logic            clk;
  logic            rst_n;
  logic [NC*W-1:0] din;
  logic [NC-1:0]   en;
  logic            mode;
  logic [SW-1:0]   sel_in;
  logic            freeze;
  logic [W-1:0]    dout;
  logic [SW-1:0]   sel_out;
  logic            valid;
  logic            strobe;

  int total = 0;
  int bad   = 0;

  scan_mux_n #(.WIDTH(W), .N(NC), .SEL_W(SW), .DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .mode(mode),
    .sel_in(sel_in), .freeze(freeze), .dout(dout), .sel_out(sel_out),
    .valid(valid), .strobe(strobe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_sel    = 0;   // channel being shown
  int   m_shown  = 0;   // cycles already spent on it in scan mode
  int   m_dout   = 0;
  bit   m_valid  = 0;
  bit   m_strobe = 0;

  function automatic int next_enabled(input int from, input logic [NC-1:0] m);
    for (int k = 1; k <= NC; k++) begin
      if (m[(from + k) % NC]) return (from + k) % NC;
    end
    return from;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_sel = 0; m_shown = 0; m_dout = 0; m_valid = 0; m_strobe = 0;
      end else begin
        int  prev_sel;
        bit  prev_valid;
        prev_sel   = m_sel;
        prev_valid = m_valid;
        if (!freeze) begin
          if (!mode) begin
            m_sel   = int'(sel_in);
            m_shown = 0;
          end else if (en == 0) begin
            m_shown = 0;
          end else if (!en[m_sel] || m_shown + 1 >= DW) begin
            m_sel   = next_enabled(m_sel, en);
            m_shown = 0;
          end else begin
            m_shown = m_shown + 1;
          end
        end
        m_valid  = en[m_sel];
        m_dout   = m_valid ? int'(din[m_sel*W +: W]) : 0;
        m_strobe = (m_sel != prev_sel) || (m_valid && !prev_valid);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("dout",    int'(dout),    m_dout);
      check("sel_out", int'(sel_out), m_sel);
      check("valid",   int'(valid),   int'(m_valid));
      check("strobe",  int'(strobe),  int'(m_strobe));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq [13];
    int s;
    int v;
    seq = '{0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3, 0};

    rst_n  = 1'b0;
    din    = {NC{10'h3FF}};
    en     = 4'hF;
    mode   = 1'b0;
    sel_in = '0;
    freeze = 1'b0;

    // Reset holds everything at zero even with all-ones data.
    #3;
    check("rst_dout",   int'(dout),    0);
    check("rst_sel",    int'(sel_out), 0);
    check("rst_valid",  int'(valid),   0);
    check("rst_strobe", int'(strobe),  0);
    #19 rst_n = 1'b1;
    tick;
    check("first_dout",   int'(dout),   10'h3FF);
    check("first_valid",  int'(valid),  1);
    check("first_strobe", int'(strobe), 1);

    // Manual selection.
    din = {10'd40, 10'd30, 10'd20, 10'd10};
    tick;
    check("man_ch0", int'(dout), 10);
    sel_in = 2'd2;
    tick;
    check("man_dout",   int'(dout),    30);
    check("man_sel",    int'(sel_out), 2);
    check("man_strobe", int'(strobe),  1);
    tick;
    check("man_strobe_off", int'(strobe), 0);
    en = 4'b1011;
    tick;
    check("man_dis_dout",  int'(dout),  0);
    check("man_dis_valid", int'(valid), 0);

    // Scan sequence from channel 0 with channel 2 skipped.
    sel_in = 2'd0;
    tick;
    mode = 1'b1;
    check("scan_seq0", int'(sel_out), seq[0]);
    for (int i = 1; i < 13; i++) begin
      tick;
      check($sformatf("scan_seq%0d", i), int'(sel_out), seq[i]);
    end

    // Disable the current channel part-way through its dwell.
    for (int i = 0; i < 12 && sel_out != 2'd1; i++) tick;
    check("reach_ch1", int'(sel_out), 1);
    tick;
    en = 4'b1001;
    tick;
    check("skip_sel",    int'(sel_out), 3);
    check("skip_strobe", int'(strobe),  1);
    tick; tick; tick;
    check("skip_full_dwell", int'(sel_out), 3);
    tick;
    check("skip_wrap", int'(sel_out), 0);
    en = 4'b0000;
    tick;
    check("none_valid", int'(valid), 0);
    check("none_dout",  int'(dout),  0);

    // Freeze: selection holds, data keeps flowing with one cycle of latency.
    en = 4'hF;
    tick; tick;
    freeze = 1'b1;
    s = int'(sel_out);
    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(0, 1023));
      din[s*W +: W] = W'(v);
      tick;
      check("frz_dout", int'(dout),    v);
      check("frz_sel",  int'(sel_out), s);
    end
    freeze = 1'b0;
    for (int i = 0; i < 6; i++) tick;

    // Asynchronous reset pulse between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout",   int'(dout),    0);
    check("arst_sel",    int'(sel_out), 0);
    check("arst_valid",  int'(valid),   0);
    check("arst_strobe", int'(strobe),  0);
    #3 rst_n = 1'b1;
    tick; tick; tick;
    check("arst_dwell_hold", int'(sel_out), 0);
    tick;
    check("arst_dwell_next", int'(sel_out), 1);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      tick;
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      din    = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
      if ($urandom_range(0, 9) == 0) en = NC'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel_in = SW'($urandom);
      freeze = ($urandom_range(0, 9) == 0);
    end
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
